// File: rtl/imem_load_ctrl_if.sv
// Loader, CPU fetch and instruction-memory signals grouped for imem_load_ctrl.
// The master modport is the controller's view; slave is the surrounding system.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic [31:0]       cpu_pc;
  logic [DATA_W-1:0] cpu_instr;
  logic              cpu_stall;
  logic              cpu_pc_reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ld_valid, ld_data, cpu_pc, mem_rdata,
    output ld_ready, cpu_instr, cpu_stall, cpu_pc_reset, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output ld_valid, ld_data, cpu_pc, mem_rdata,
    input  ld_ready, cpu_instr, cpu_stall, cpu_pc_reset, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Arbitrates a single-port instruction memory between CPU fetch and a word loader,
// stalling the CPU during a load and holding its PC in reset for a short flush window.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_start,
  input  logic                load_abort,
  input  logic [ADDR_W-1:0]   load_base,
  input  logic [ADDR_W:0]     load_count,
  imem_load_ctrl_if.master    bus,
  output logic                busy,
  output logic [ADDR_W:0]     words_loaded,
  output logic                load_err
);

  localparam int unsigned FlushW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StRun, StLoad, StFlush} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     remaining_q;
  logic [FlushW-1:0]   flush_cnt_q;
  logic [ADDR_W:0]     words_loaded_q;
  logic                load_err_q;

  logic count_ok;
  logic hs;
  logic unused_pc;

  assign count_ok  = (load_count != '0) && (load_count <= MaxCount);
  assign hs        = (state_q == StLoad) && bus.ld_valid;
  assign unused_pc = ^{bus.cpu_pc[31:ADDR_W+2], bus.cpu_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StRun;
      wr_ptr_q       <= '0;
      remaining_q    <= '0;
      flush_cnt_q    <= '0;
      words_loaded_q <= '0;
      load_err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_start) begin
            if (count_ok) begin
              state_q        <= StLoad;
              wr_ptr_q       <= load_base;
              remaining_q    <= load_count;
              words_loaded_q <= '0;
              load_err_q     <= 1'b0;
            end else begin
              load_err_q     <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (hs) begin
            wr_ptr_q       <= wr_ptr_q + ADDR_W'(1);
            remaining_q    <= remaining_q - (ADDR_W+1)'(1);
            words_loaded_q <= words_loaded_q + (ADDR_W+1)'(1);
          end
          // An abort coincident with a handshake still lets that word count.
          if (load_abort || (hs && remaining_q == (ADDR_W+1)'(1))) begin
            state_q     <= StFlush;
            flush_cnt_q <= FlushW'(FLUSH_CYCLES);
          end
        end
        StFlush: begin
          if (flush_cnt_q <= FlushW'(1)) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q - FlushW'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    bus.ld_ready     = (state_q == StLoad);
    bus.cpu_stall    = (state_q != StRun);
    bus.cpu_pc_reset = (state_q == StFlush);
    bus.cpu_instr    = (state_q == StRun) ? bus.mem_rdata : '0;
    bus.mem_addr     = (state_q == StLoad) ? wr_ptr_q : bus.cpu_pc[ADDR_W+1:2];
    bus.mem_wdata    = bus.ld_data;
    // Gated by reset so a reset landing mid-load never writes.
    bus.mem_we       = hs && !reset;
  end

  assign busy         = (state_q != StRun);
  assign words_loaded = words_loaded_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: fetch path, loads, gaps, wrap, abort,
// illegal counts and reset mid-load.
module tb_imem_load_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_abort;
  logic [7:0] load_base;
  logic [8:0] load_count;
  logic       busy;
  logic [8:0] words_loaded;
  logic       load_err;

  int errors = 0;
  int checks = 0;

  imem_load_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  imem_load_ctrl #(.ADDR_W(8), .DATA_W(32), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_start   (load_start),
    .load_abort   (load_abort),
    .load_base    (load_base),
    .load_count   (load_count),
    .bus          (bus),
    .busy         (busy),
    .words_loaded (words_loaded),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [7:0] addr, input logic [31:0] data);
    check_eq({tag, "_we"}, 64'(bus.mem_we), 64'd1);
    check_eq({tag, "_addr"}, 64'(bus.mem_addr), 64'(addr));
    check_eq({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(data));
    check_eq({tag, "_stall"}, 64'(bus.cpu_stall), 64'd1);
    check_eq({tag, "_instr"}, 64'(bus.cpu_instr), 64'd0);
  endtask

  task automatic chk_flush(input string tag);
    check_eq({tag, "_pcrst"}, 64'(bus.cpu_pc_reset), 64'd1);
    check_eq({tag, "_we"}, 64'(bus.mem_we), 64'd0);
    check_eq({tag, "_rdy"}, 64'(bus.ld_ready), 64'd0);
    check_eq({tag, "_addr"}, 64'(bus.mem_addr), 64'd4);
  endtask

  task automatic chk_run(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_stall"}, 64'(bus.cpu_stall), 64'd0);
    check_eq({tag, "_pcrst"}, 64'(bus.cpu_pc_reset), 64'd0);
    check_eq({tag, "_instr"}, 64'(bus.cpu_instr), 64'h00432020);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load_start = 1'b0; load_abort = 1'b0;
    load_base = '0; load_count = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.cpu_pc = '0; bus.mem_rdata = '0;
    repeat (3) tick();

    // Fetch path after reset; load_abort must be ignored in RUN.
    reset = 1'b0; bus.cpu_pc = 32'h10; bus.mem_rdata = 32'h00432020; load_abort = 1'b1;
    settle();
    check_eq("rst_instr", 64'(bus.cpu_instr), 64'h00432020);
    check_eq("rst_addr", 64'(bus.mem_addr), 64'd4);
    check_eq("rst_stall", 64'(bus.cpu_stall), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_we", 64'(bus.mem_we), 64'd0);
    check_eq("rst_rdy", 64'(bus.ld_ready), 64'd0);
    check_eq("rst_pcrst", 64'(bus.cpu_pc_reset), 64'd0);
    check_eq("rst_wl", 64'(words_loaded), 64'd0);
    check_eq("rst_err", 64'(load_err), 64'd0);
    tick();
    load_abort = 1'b0;
    settle();
    check_eq("abort_in_run", 64'(busy), 64'd0);

    // Full load: base 4, 3 words, continuous valid.
    load_start = 1'b1; load_base = 8'd4; load_count = 9'd3;
    bus.ld_valid = 1'b1; bus.ld_data = 32'hA;
    settle();
    check_eq("start_no_we", 64'(bus.mem_we), 64'd0);
    tick(); load_start = 1'b0; settle();
    check_eq("l1_rdy", 64'(bus.ld_ready), 64'd1);
    check_eq("l1_busy", 64'(busy), 64'd1);
    chk_write("l1w0", 8'd4, 32'hA);
    tick(); bus.ld_data = 32'hB; load_start = 1'b1; settle();
    chk_write("l1w1", 8'd5, 32'hB);
    tick(); bus.ld_data = 32'hC; load_start = 1'b0; settle();
    chk_write("l1w2", 8'd6, 32'hC);
    tick(); bus.ld_valid = 1'b0; settle();
    chk_flush("l1f0");
    check_eq("l1_wl", 64'(words_loaded), 64'd3);
    tick(); settle();
    chk_flush("l1f1");
    tick(); settle();
    chk_run("l1_run");

    // Loader gaps: 2 words with valid pattern 1,0,0,1.
    load_start = 1'b1; load_base = 8'h20; load_count = 9'd2;
    tick(); load_start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 32'h11; settle();
    chk_write("g_w0", 8'h20, 32'h11);
    tick(); bus.ld_valid = 1'b0; settle();
    check_eq("g_gap0_we", 64'(bus.mem_we), 64'd0);
    check_eq("g_gap0_rdy", 64'(bus.ld_ready), 64'd1);
    tick(); settle();
    check_eq("g_gap1_we", 64'(bus.mem_we), 64'd0);
    check_eq("g_gap1_wl", 64'(words_loaded), 64'd1);
    tick(); bus.ld_valid = 1'b1; bus.ld_data = 32'h22; settle();
    chk_write("g_w1", 8'h21, 32'h22);
    tick(); bus.ld_valid = 1'b0; settle();
    chk_flush("g_f0");
    check_eq("g_wl", 64'(words_loaded), 64'd2);
    repeat (2) tick();
    settle();
    chk_run("g_run");

    // Address wrap: base 254, 4 words.
    load_start = 1'b1; load_base = 8'd254; load_count = 9'd4;
    tick(); load_start = 1'b0; bus.ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ld_data = 32'h100 + 32'(i);
      settle();
      chk_write("wrap", 8'(254 + i), 32'h100 + 32'(i));
      tick();
    end
    bus.ld_valid = 1'b0; settle();
    chk_flush("wrap_f");
    check_eq("wrap_wl", 64'(words_loaded), 64'd4);
    check_eq("wrap_err", 64'(load_err), 64'd0);
    repeat (2) tick();
    settle();
    chk_run("wrap_run");

    // Abort coincident with the second handshake of a 5-word load.
    load_start = 1'b1; load_base = 8'h40; load_count = 9'd5;
    tick(); load_start = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 32'hD1; settle();
    chk_write("ab_w0", 8'h40, 32'hD1);
    tick(); bus.ld_data = 32'hD2; load_abort = 1'b1; settle();
    chk_write("ab_w1", 8'h41, 32'hD2);
    tick(); bus.ld_valid = 1'b0; load_abort = 1'b0; settle();
    chk_flush("ab_f0");
    check_eq("ab_wl", 64'(words_loaded), 64'd2);
    tick(); settle();
    chk_flush("ab_f1");
    tick(); settle();
    chk_run("ab_run");

    // Illegal counts 0 and 257, then a legal start clears the flag.
    load_start = 1'b1; load_base = 8'h80; load_count = 9'd0; bus.ld_valid = 1'b1;
    tick(); settle();
    check_eq("ill0_err", 64'(load_err), 64'd1);
    check_eq("ill0_busy", 64'(busy), 64'd0);
    check_eq("ill0_we", 64'(bus.mem_we), 64'd0);
    load_count = 9'd257;
    tick(); settle();
    check_eq("ill257_err", 64'(load_err), 64'd1);
    check_eq("ill257_busy", 64'(busy), 64'd0);
    check_eq("ill257_wl", 64'(words_loaded), 64'd2);
    load_count = 9'd3; bus.ld_data = 32'hE0;
    tick(); load_start = 1'b0; settle();
    check_eq("legal_err", 64'(load_err), 64'd0);
    check_eq("legal_wl", 64'(words_loaded), 64'd0);
    chk_write("legal_w0", 8'h80, 32'hE0);

    // Synchronous reset mid-load with valid held high.
    tick(); reset = 1'b1; bus.ld_data = 32'hE1; settle();
    check_eq("mid_wl", 64'(words_loaded), 64'd1);
    check_eq("mid_rst_we", 64'(bus.mem_we), 64'd0);
    tick(); reset = 1'b0; settle();
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    check_eq("post_rst_we", 64'(bus.mem_we), 64'd0);
    check_eq("post_rst_wl", 64'(words_loaded), 64'd0);
    check_eq("post_rst_rdy", 64'(bus.ld_ready), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
